// File: rtl/response_collector_if.sv
// Bundle between the PUF sequencer/consumer (master) and the response collector (slave).
interface response_collector_if #(
    parameter int NUM_LOOPS = 4,
    parameter int SEL_W     = $clog2(NUM_LOOPS - 1) + 1
);
    logic                 start;
    logic [SEL_W-1:0]     select_puf;
    logic                 store_response_puf;
    logic                 puf_bit;
    logic                 done;
    logic [NUM_LOOPS-1:0] response;
    logic [NUM_LOOPS-1:0] unstable;
    logic                 response_valid;
    logic                 response_ack;
    logic                 sel_error;

    modport master (
        output start, select_puf, store_response_puf, puf_bit, done, response_ack,
        input  response, unstable, response_valid, sel_error
    );

    modport slave (
        input  start, select_puf, store_response_puf, puf_bit, done, response_ack,
        output response, unstable, response_valid, sel_error
    );
endinterface

// File: rtl/response_collector.sv
// Majority-votes repeated single-bit PUF evaluations per loop into a stable response,
// flagging loops that tied or were never sampled.
module response_collector #(
    parameter  int NUM_LOOPS  = 4,
    parameter  int COUNT_BITS = 16,
    localparam int SEL_W      = $clog2(NUM_LOOPS - 1) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    response_collector_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, VALID} state_e;

    localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

    state_e                  state_q, state_d;
    logic [COUNT_BITS-1:0]   ones_q  [NUM_LOOPS];
    logic [COUNT_BITS-1:0]   ones_d  [NUM_LOOPS];
    logic [COUNT_BITS-1:0]   total_q [NUM_LOOPS];
    logic [COUNT_BITS-1:0]   total_d [NUM_LOOPS];
    logic [NUM_LOOPS-1:0]    response_q, response_d;
    logic [NUM_LOOPS-1:0]    unstable_q, unstable_d;
    logic                    sel_error_q, sel_error_d;
    logic                    sel_in_range;

    always_comb begin
        sel_in_range = 1'b0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            if (bus.select_puf == SEL_W'(i)) sel_in_range = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        total_d     = total_q;
        response_d  = response_q;
        unstable_d  = unstable_q;
        sel_error_d = sel_error_q;

        if (bus.start) begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                ones_d[i]  = '0;
                total_d[i] = '0;
            end
            sel_error_d = 1'b0;
            state_d     = COLLECT;
        end else begin
            unique case (state_q)
                IDLE: ;
                COLLECT: begin
                    if (bus.store_response_puf) begin
                        if (!sel_in_range) sel_error_d = 1'b1;
                        for (int i = 0; i < NUM_LOOPS; i++) begin
                            // A loop whose total has saturated stops voting entirely.
                            if (bus.select_puf == SEL_W'(i) && total_q[i] != CNT_MAX) begin
                                total_d[i] = total_q[i] + 1'b1;
                                if (bus.puf_bit && ones_q[i] != CNT_MAX)
                                    ones_d[i] = ones_q[i] + 1'b1;
                            end
                        end
                    end
                    if (bus.done) state_d = RESOLVE;
                end
                RESOLVE: begin
                    // One extra bit keeps 2*ones from overflowing against total.
                    for (int i = 0; i < NUM_LOOPS; i++) begin
                        response_d[i] = {ones_q[i], 1'b0} >  {1'b0, total_q[i]};
                        unstable_d[i] = {ones_q[i], 1'b0} == {1'b0, total_q[i]};
                    end
                    state_d = VALID;
                end
                VALID: begin
                    if (bus.response_ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            response_q  <= '0;
            unstable_q  <= '0;
            sel_error_q <= 1'b0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                ones_q[i]  <= '0;
                total_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            response_q  <= response_d;
            unstable_q  <= unstable_d;
            sel_error_q <= sel_error_d;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                ones_q[i]  <= ones_d[i];
                total_q[i] <= total_d[i];
            end
        end
    end

    assign bus.response       = response_q;
    assign bus.unstable       = unstable_q;
    assign bus.response_valid = (state_q == VALID);
    assign bus.sel_error      = sel_error_q;
endmodule

// File: tb/tb_response_collector.sv
// Directed bench for response_collector: a vote-counting reference model checked every cycle,
// plus literal expectations for the key scenarios (small counters so saturation is reachable).
module tb_response_collector;
    localparam int NL      = 4;
    localparam int CB      = 3;
    localparam int CNT_MAX = (1 << CB) - 1;

    logic clk;
    logic reset;
    response_collector_if #(.NUM_LOOPS(NL)) bus ();

    response_collector #(.NUM_LOOPS(NL), .COUNT_BITS(CB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 0;

    // Reference model: raw vote tallies and whether a result is pending or presented.
    int       m_ones [NL];
    int       m_total[NL];
    bit [3:0] m_resp, m_unst;
    bit       m_collect, m_resolve, m_valid, m_selerr;

    always @(posedge clk) begin
        if (reset) begin
            foreach (m_ones[i]) begin m_ones[i] = 0; m_total[i] = 0; end
            m_resp = 0; m_unst = 0; m_selerr = 0;
            m_collect = 0; m_resolve = 0; m_valid = 0;
        end else if (bus.start) begin
            foreach (m_ones[i]) begin m_ones[i] = 0; m_total[i] = 0; end
            m_selerr = 0; m_collect = 1; m_resolve = 0; m_valid = 0;
        end else if (m_collect) begin
            if (bus.store_response_puf) begin
                if (int'(bus.select_puf) >= NL) m_selerr = 1;
                else if (m_total[bus.select_puf] < CNT_MAX) begin
                    m_total[bus.select_puf]++;
                    if (bus.puf_bit) m_ones[bus.select_puf]++;
                end
            end
            if (bus.done) begin m_collect = 0; m_resolve = 1; end
        end else if (m_resolve) begin
            foreach (m_ones[i]) begin
                m_resp[i] = (2 * m_ones[i]) > m_total[i];
                m_unst[i] = (2 * m_ones[i]) == m_total[i];
            end
            m_resolve = 0; m_valid = 1;
        end else if (m_valid && bus.response_ack) begin
            m_valid = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model.response",       32'(bus.response),       32'(m_resp));
            checkOutput("model.unstable",       32'(bus.unstable),       32'(m_unst));
            checkOutput("model.response_valid", 32'(bus.response_valid), 32'(m_valid));
            checkOutput("model.sel_error",      32'(bus.sel_error),      32'(m_selerr));
        end
    end

    task automatic applyStimulus(input bit st, input bit strb, input int sel, input bit pb,
                                 input bit dn, input bit ack, input bit rst);
        bus.start              = st;
        bus.store_response_puf = strb;
        bus.select_puf         = 3'(sel);
        bus.puf_bit            = pb;
        bus.done               = dn;
        bus.response_ack       = ack;
        reset                  = rst;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic strobe(input int sel, input bit pb);
        applyStimulus(0, 1, sel, pb, 0, 0, 0);
    endtask

    task automatic startRun();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic finishRun();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(1);
    endtask

    task automatic ack();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        cmp_en = 1;
        checkOutput("reset.response",       32'(bus.response),       0);
        checkOutput("reset.unstable",       32'(bus.unstable),       0);
        checkOutput("reset.response_valid", 32'(bus.response_valid), 0);
        checkOutput("reset.sel_error",      32'(bus.sel_error),      0);

        // Basic majority with latency check.
        startRun();
        strobe(0, 1); strobe(0, 1); strobe(0, 0);
        for (int l = 1; l < NL; l++) begin strobe(l, 0); strobe(l, 0); strobe(l, 1); end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("majority.valid_resolve", 32'(bus.response_valid), 0);
        idle(1);
        checkOutput("majority.valid",    32'(bus.response_valid), 1);
        checkOutput("majority.response", 32'(bus.response),       32'h1);
        checkOutput("majority.unstable", 32'(bus.unstable),       32'h0);
        ack();
        checkOutput("majority.ack_valid", 32'(bus.response_valid), 0);

        // Ties, empty loop, held handshake, ignored strobes/done in IDLE.
        startRun();
        strobe(0, 1); strobe(0, 1);
        strobe(1, 0); strobe(1, 0);
        strobe(2, 1); strobe(2, 0);
        finishRun();
        checkOutput("tie.response", 32'(bus.response), 32'h1);
        checkOutput("tie.unstable", 32'(bus.unstable), 32'hC);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checkOutput("hold.valid",    32'(bus.response_valid), 1);
            checkOutput("hold.response", 32'(bus.response),       32'h1);
        end
        ack();
        checkOutput("hold.ack_valid", 32'(bus.response_valid), 0);
        strobe(1, 1); strobe(1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        checkOutput("idle.valid",    32'(bus.response_valid), 0);
        checkOutput("idle.response", 32'(bus.response),       32'h1);
        checkOutput("idle.unstable", 32'(bus.unstable),       32'hC);

        // Strobe on the done cycle is counted: loop 0 becomes a 1/2 tie.
        startRun();
        strobe(0, 0);
        applyStimulus(0, 1, 0, 1, 1, 0, 0);
        idle(1);
        checkOutput("donestrobe.response", 32'(bus.response), 32'h0);
        checkOutput("donestrobe.unstable", 32'(bus.unstable), 32'hF);
        ack();

        // Start together with a strobe drops the strobe.
        startRun();
        strobe(1, 1); strobe(1, 1);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        strobe(0, 1);
        finishRun();
        checkOutput("startstrobe.response", 32'(bus.response), 32'h1);
        checkOutput("startstrobe.unstable", 32'(bus.unstable), 32'hE);
        ack();

        // Out-of-range select.
        startRun();
        strobe(5, 1);
        checkOutput("selerr.set", 32'(bus.sel_error), 1);
        strobe(0, 1);
        finishRun();
        checkOutput("selerr.response", 32'(bus.response),  32'h1);
        checkOutput("selerr.unstable", 32'(bus.unstable),  32'hE);
        checkOutput("selerr.sticky",   32'(bus.sel_error), 1);
        startRun();
        checkOutput("selerr.cleared",  32'(bus.sel_error), 0);

        // Reset mid-collect discards votes.
        strobe(0, 1); strobe(0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("rst.response", 32'(bus.response),       0);
        checkOutput("rst.unstable", 32'(bus.unstable),       0);
        checkOutput("rst.valid",    32'(bus.response_valid), 0);
        startRun();
        strobe(0, 0);
        finishRun();
        checkOutput("rst.rerun_response", 32'(bus.response), 32'h0);
        checkOutput("rst.rerun_unstable", 32'(bus.unstable), 32'hE);
        ack();

        // Saturation (loop 0) and wide comparison at 4 of 7 (loop 1).
        startRun();
        for (int i = 0; i < 7; i++) strobe(0, 0);
        for (int i = 0; i < 3; i++) strobe(0, 1);
        for (int i = 0; i < 4; i++) strobe(1, 1);
        for (int i = 0; i < 3; i++) strobe(1, 0);
        finishRun();
        checkOutput("sat.response", 32'(bus.response), 32'h2);
        checkOutput("sat.unstable", 32'(bus.unstable), 32'hC);
        ack();
        idle(2);

        cmp_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
